// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   state_e       : fetch controller states
//   fetch_entry_t : one fetched instruction with its address
//   INSTR_BYTES   : PC increment per fetched instruction
//   pc_is_legal() : alignment and range check of a fetch address
package imem_fetch_ctrl_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        StRun,
        StHalted,
        StFault
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // last_pc is the highest address at which a whole word still fits in memory
    function automatic logic pc_is_legal(input logic [31:0] pc, input logic [31:0] last_pc);
        return (pc[1:0] == 2'b00) && (pc <= last_pc);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch controller and its environment.
//   mem_addr / mem_instr                  : instruction memory read port
//   redirect_valid / redirect_pc          : branch/jump redirect
//   halt_req                              : level request to stop fetching
//   out_valid / out_ready / out_instr / out_pc : decode-side queue head
//   fault / fault_pc                      : fetch fault status
//   fetch_cnt                             : instructions pushed since reset
// master: the fetch controller side; slave: the environment side.
interface imem_fetch_ctrl_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_cnt;

    modport master (
        output mem_addr, out_valid, out_instr, out_pc, fault, fault_pc, fetch_cnt,
        input  mem_instr, redirect_valid, redirect_pc, halt_req, out_ready
    );

    modport slave (
        input  mem_addr, out_valid, out_instr, out_pc, fault, fault_pc, fetch_cnt,
        output mem_instr, redirect_valid, redirect_pc, halt_req, out_ready
    );

endinterface

// File: rtl/imem_fetch_ctrl_fetch_fifo2.sv
// Two-entry FIFO of fetched {pc, instr} entries.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_entry at the tail
//   pop        : drop the head entry
//   flush      : discard all entries (overrides push/pop)
//   head       : registered head entry
//   count      : number of valid entries (0..2)
module fetch_fifo2
    import imem_fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok, push_ok;
    logic [1:0]   slot;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != 2'd0);
        push_ok = push && ((count_q != 2'd2) || pop_ok);
        // Tail slot once this cycle's pop has shifted the queue forward
        slot    = count_q - {1'b0, pop_ok};
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop_ok) begin
                e0_d = e1_q;
            end
            if (push_ok) begin
                if (slot == 2'd0) begin
                    e0_d = push_entry;
                end else begin
                    e1_d = push_entry;
                end
            end
            count_d = slot + {1'b0, push_ok};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign head  = e0_q;
    assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks the PC through an external instruction
// memory, queues fetched words in a 2-entry FIFO for decode, and handles
// redirects, halt requests and illegal-PC faults.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : imem_fetch_ctrl_if master (memory port, redirect, halt, decode
//              queue head, fault status, fetch counter)
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic               clk,
    input  logic               rst,
    imem_fetch_ctrl_if.master  bus
);

    localparam logic [31:0] LastPc = 32'(MEM_BYTES - INSTR_BYTES);

    state_e       state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic [31:0]  fetch_cnt_q, fetch_cnt_d;
    logic         push, pop, flush;
    logic [1:0]   count;
    fetch_entry_t head, push_entry;

    assign pop = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        fault_pc_d       = fault_pc_q;
        fetch_cnt_d      = fetch_cnt_q;
        push             = 1'b0;
        flush            = 1'b0;
        push_entry.pc    = pc_q;
        push_entry.instr = bus.mem_instr;
        if (bus.redirect_valid) begin
            flush   = 1'b1;
            pc_d    = bus.redirect_pc;
            state_d = bus.halt_req ? StHalted : StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (bus.halt_req) begin
                        state_d = StHalted;
                    end else if (!pc_is_legal(pc_q, LastPc)) begin
                        state_d    = StFault;
                        fault_pc_d = pc_q;
                    end else if ((count != 2'd2) || pop) begin
                        push        = 1'b1;
                        pc_d        = pc_q + INSTR_BYTES;
                        fetch_cnt_d = fetch_cnt_q + 32'd1;
                    end
                end
                StHalted: begin
                    if (!bus.halt_req) begin
                        state_d = StRun;
                    end
                end
                StFault: begin
                    // Only a redirect leaves the fault state
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            fault_pc_q  <= 32'd0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fault_pc_q  <= fault_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    fetch_fifo2 u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    assign bus.mem_addr  = pc_q;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
    assign bus.fault     = (state_q == StFault);
    assign bus.fault_pc  = fault_pc_q;
    assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model and a
// scoreboard of expected decode-side deliveries.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned MEM_BYTES = 256;

    logic clk;
    logic rst;
    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External instruction memory, big-endian words
    logic [7:0] mem [0:MEM_BYTES-1];
    logic [7:0] rd_a;
    always_comb begin
        rd_a = 8'd0;
        bus.mem_instr = 32'hDEAD_BEEF;
        if (bus.mem_addr <= 32'(MEM_BYTES - 4)) begin
            rd_a = bus.mem_addr[7:0];
            bus.mem_instr = {mem[rd_a], mem[rd_a + 8'd1], mem[rd_a + 8'd2], mem[rd_a + 8'd3]};
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds what decode should see, in order
    logic [63:0] mq [$];
    logic [63:0] sb [$];
    logic [31:0] m_pc, m_fpc, m_cnt;
    logic        m_halted, m_faulted;

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_pc      = RESET_PC;
        m_fpc     = 32'd0;
        m_cnt     = 32'd0;
        m_halted  = 1'b0;
        m_faulted = 1'b0;
    endtask

    // Applies one clock edge worth of behaviour using the inputs held across it
    task automatic model_step();
        logic        pop;
        logic [63:0] e;
        if (rst) return;
        pop = (mq.size() != 0) && bus.out_ready;
        if (bus.redirect_valid) begin
            mq.delete();
            sb.delete();
            m_pc      = bus.redirect_pc;
            m_halted  = bus.halt_req;
            m_faulted = 1'b0;
            return;
        end
        if (pop) mq.delete(0);
        if (m_faulted) begin
        end else if (m_halted) begin
            m_halted = bus.halt_req;
        end else if (bus.halt_req) begin
            m_halted = 1'b1;
        end else if ((m_pc % 4 != 0) || (m_pc > 32'(MEM_BYTES - 4))) begin
            m_faulted = 1'b1;
            m_fpc     = m_pc;
        end else if (mq.size() < 2) begin
            e = {m_pc, mem_word(m_pc)};
            mq.push_back(e);
            sb.push_back(e);
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    // Monitor: compares state every cycle and pops the scoreboard on each handshake
    logic [63:0] exp_e;
    always @(negedge clk) begin
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
        check("mem_addr", bus.mem_addr, m_pc);
        check("fault", {31'd0, bus.fault}, {31'd0, m_faulted});
        check("fault_pc", bus.fault_pc, m_fpc);
        check("fetch_cnt", bus.fetch_cnt, m_cnt);
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: delivery pc %h with nothing expected", bus.out_pc);
            end else begin
                exp_e = sb.pop_front();
                check("out_pc", bus.out_pc, exp_e[63:32]);
                check("out_instr", bus.out_instr, exp_e[31:0]);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        cycle();
        cycle();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, RESET_PC);
        rst = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        cycle();
        bus.redirect_valid = 1'b0;
    endtask

    int          r;
    logic [31:0] rpc;
    bit          reached;

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.halt_req       = 1'b0;
        bus.out_ready      = 1'b1;
        model_reset();
        rst = 1'b0;
        #1;
        apply_reset();

        // Streaming with decode always ready
        repeat (4) cycle();
        check("stream_cnt", bus.fetch_cnt, 32'd4);

        // Decode stalled: queue saturates at two entries
        bus.out_ready = 1'b0;
        apply_reset();
        repeat (5) cycle();
        check("stall_cnt", bus.fetch_cnt, 32'd2);
        check("stall_pc", bus.mem_addr, 32'h8);
        check("stall_head", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        repeat (4) cycle();

        // Redirect with a full queue
        bus.out_ready = 1'b0;
        repeat (3) cycle();
        redirect_to(32'h40);
        check("redir_flush", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        cycle();
        check("redir_head", bus.out_pc, 32'h40);
        cycle();

        // Misaligned redirect faults; a legal redirect recovers
        redirect_to(32'h42);
        cycle();
        check("mis_fault", {31'd0, bus.fault}, 32'd1);
        check("mis_fault_pc", bus.fault_pc, 32'h42);
        redirect_to(32'h10);
        check("recover_fault", {31'd0, bus.fault}, 32'd0);
        cycle();
        check("recover_head", bus.out_pc, 32'h10);

        // Halt exactly when the PC reaches 0x20
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (m_pc == 32'h20) reached = 1'b1;
            else cycle();
        end
        if (!reached) begin
            n_checks++;
            n_fail++;
            $display("FAIL halt_reach: pc %h never reached 00000020", m_pc);
        end
        bus.halt_req = 1'b1;
        repeat (4) cycle();
        check("halt_pc", bus.mem_addr, 32'h20);
        check("halt_drained", {31'd0, bus.out_valid}, 32'd0);
        bus.halt_req = 1'b0;
        cycle();
        cycle();
        check("resume_head", bus.out_pc, 32'h20);

        // Run off the end of memory
        redirect_to(32'hF0);
        repeat (8) cycle();
        check("end_fault", {31'd0, bus.fault}, 32'd1);
        check("end_fault_pc", bus.fault_pc, 32'h100);

        // Randomized traffic with a mid-run reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                bus.out_ready = 1'b0;
                apply_reset();
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) bus.halt_req = ~bus.halt_req;
            bus.redirect_valid = ($urandom_range(0, 11) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 7) rpc = 32'($urandom_range(0, 63)) * 32'd4;
            else if (r == 7) rpc = 32'($urandom_range(0, 255));
            else if (r == 8) rpc = 32'hF0;
            else rpc = 32'($urandom_range(256, 300)) & 32'hFFFF_FFFC;
            bus.redirect_pc = rpc;
            cycle();
        end
        bus.redirect_valid = 1'b0;
        bus.halt_req       = 1'b0;
        bus.out_ready      = 1'b1;
        repeat (4) cycle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter MEM_BYTES, default 256, instruction memory size in bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mem_addr  output  32  byte address to instruction memory; always equals PC.
REQ-006 SHALL have port mem_instr  input  32  combinational read data for mem_addr, big-endian word.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target.
REQ-009 SHALL have port halt_req  input  1  level request to stop fetching.
REQ-010 SHALL have port out_valid  output  1  queue head valid to decode.
REQ-011 SHALL have port out_ready  input  1  decode accepts head.
REQ-012 SHALL have port out_instr  output  32  head instruction.
REQ-013 SHALL have port out_pc  output  32  head instruction address.
REQ-014 SHALL have port fault  output  1  high while in FAULT state.
REQ-015 SHALL have port fault_pc  output  32  PC that caused the fault.
REQ-016 SHALL have port fetch_cnt  output  32  count of instructions pushed since reset.

Function
REQ-017 SHALL implement states RUN, HALTED, FAULT; PC register; 2-entry FIFO of {pc, instr}.
REQ-018 Issue condition: state==RUN, no redirect, PC legal, and (count<2 or pop this cycle).
REQ-019 On issue SHALL push {PC, mem_instr} and set PC <= PC+4, modulo 2^32; fetch_cnt +1 (wraps).
REQ-020 Pop = out_valid && out_ready; out_valid = (count!=0); out_instr/out_pc from head, registered.
REQ-021 Push and pop in same cycle with count==2 SHALL be allowed; count unchanged, order preserved.
REQ-022 PC illegal if PC[1:0]!=0 or PC > MEM_BYTES-4; in RUN SHALL enter FAULT, no push, fault_pc <= PC.
REQ-023 FAULT SHALL hold PC, keep draining existing FIFO entries, issue nothing.
REQ-024 RUN -> HALTED when halt_req==1 (no issue that cycle); HALTED -> RUN when halt_req==0.
REQ-025 HALTED SHALL keep draining FIFO; PC held.
REQ-026 redirect_valid SHALL have highest priority: FIFO flushed (count=0), PC <= redirect_pc, no push that cycle.
REQ-027 Redirect SHALL move state to RUN from any state unless halt_req==1, then HALTED; fault clears.
REQ-028 Pop coincident with redirect SHALL count as accepted by decode; entry discarded by flush anyway.
REQ-029 Fetch latency: instruction at PC visible on out_* one cycle after issue.
REQ-030 fault_pc SHALL hold its value until next fault; fault = (state==FAULT).

Reset
REQ-031 rst SHALL asynchronously set PC=RESET_PC, state=RUN, count=0, fetch_cnt=0, fault_pc=0.
REQ-032 During/after reset out_valid=0, fault=0, mem_addr=RESET_PC; first issue on first edge after rst deasserts.
REQ-033 Reset mid-operation SHALL discard all FIFO contents with no partial output.

Structure
REQ-034 Shared package SHALL hold state enum (RUN, HALTED, FAULT), fetch-entry struct {pc, instr}, constant INSTR_BYTES=4.
REQ-035 The FIFO SHALL be sub-module fetch_fifo2 (2-entry, push/pop/flush, count output).
REQ-036 Memory array SHALL remain external; this block only drives mem_addr.

Verification
REQ-037 Reset, out_ready=1, memory words at 0,4,8 -> out_pc 0,4,8 on consecutive cycles from cycle 2, fetch_cnt=3.
REQ-038 out_ready=0 for 5 cycles -> count saturates at 2, PC=8, fetch_cnt=2; release -> pc 0,4,8 in order, none lost.
REQ-039 Redirect to 0x40 with 2 entries queued -> out_valid=0 next cycle, then out_pc=0x40, 0x44.
REQ-040 Redirect to 0x42 -> fault=1, fault_pc=0x42, no push; redirect to 0x10 -> fault=0, out_pc=0x10.
REQ-041 MEM_BYTES=256, PC reaches 0xFC -> 0xFC delivered, then fault=1, fault_pc=0x100.
REQ-042 halt_req=1 at PC=0x20 -> no issue, FIFO drains, PC stays 0x20; halt_req=0 -> next out_pc 0x20.
